// File: rtl/move_cmd_cond.sv
// Command conditioning ahead of the TR_P move controller: sync, debounce, edge detect,
// priority arbitration and post-command holdoff for the four push-button inputs.
module move_cmd_cond #(
    parameter int DEB_CYCLES     = 500000,
    parameter int DEB_W          = 20,
    parameter int HOLDOFF_CYCLES = 1000,
    parameter int HOLD_W         = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_start_n,
    input  logic btn_stop,
    input  logic btn_avto,
    output logic start,
    output logic start_N,
    output logic stop,
    output logic avto,
    output logic busy,
    output logic rejected
);

    // Channel order doubles as priority order: 0=stop, 1=start, 2=start_N, 3=avto.
    localparam int NCH = 4;
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);

    logic [NCH-1:0]            btn;
    logic [NCH-1:0]            s1_q, s1_d;
    logic [NCH-1:0]            s2_q, s2_d;
    logic [NCH-1:0]            stable_q, stable_d;
    logic [NCH-1:0]            prev_q, prev_d;
    logic [NCH-1:0][DEB_W-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0]         hold_q, hold_d;
    logic [NCH-1:0]            cmd_q, cmd_d;
    logic                      busy_q, busy_d;
    logic                      rej_q, rej_d;
    logic [NCH-1:0]            req;
    logic [NCH-1:0]            grant;
    logic                      blocked;

    assign btn = {btn_avto, btn_start_n, btn_start, btn_stop};

    always_comb begin
        s1_d     = btn;
        s2_d     = s1_q;
        prev_d   = stable_q;
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    assign req = stable_q & ~prev_q;

    // A counter of 1 expires on this very edge, so a request here lands exactly
    // HOLDOFF_CYCLES after the previous command and is allowed through.
    assign blocked = (hold_q > HOLD_W'(1));

    always_comb begin
        grant = '0;
        if (req[0]) begin
            grant[0] = 1'b1;
        end else if (!blocked) begin
            if (req[1])      grant[1] = 1'b1;
            else if (req[2]) grant[2] = 1'b1;
            else if (req[3]) grant[3] = 1'b1;
        end
    end

    always_comb begin
        cmd_d = grant;
        rej_d = |(req & ~grant);
        if (|grant[3:1]) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end else begin
            hold_d = hold_q;
        end
        busy_d = (hold_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            cmd_q    <= '0;
            busy_q   <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            cmd_q    <= cmd_d;
            busy_q   <= busy_d;
            rej_q    <= rej_d;
        end
    end

    assign stop     = cmd_q[0];
    assign start    = cmd_q[1];
    assign start_N  = cmd_q[2];
    assign avto     = cmd_q[3];
    assign busy     = busy_q;
    assign rejected = rej_q;

endmodule

// File: tb/tb_move_cmd_cond.sv
// Scoreboard bench for move_cmd_cond with DEB_CYCLES=4, HOLDOFF_CYCLES=16.
module tb_move_cmd_cond;

    logic clk = 1'b0;
    logic rst;
    logic btn_start, btn_start_n, btn_stop, btn_avto;
    logic start, start_N, stop, avto, busy, rejected;

    move_cmd_cond #(
        .DEB_CYCLES(4), .DEB_W(3), .HOLDOFF_CYCLES(16), .HOLD_W(5)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_start_n(btn_start_n),
        .btn_stop(btn_stop), .btn_avto(btn_avto),
        .start(start), .start_N(start_N), .stop(stop), .avto(avto),
        .busy(busy), .rejected(rejected)
    );

    always #10 clk = ~clk;

    // Output vector layout: {start, start_N, stop, avto, rejected}
    localparam logic [4:0] E_START  = 5'b10000;
    localparam logic [4:0] E_STARTN = 5'b01000;
    localparam logic [4:0] E_STOP   = 5'b00100;
    localparam logic [4:0] E_AVTO   = 5'b00010;
    localparam logic [4:0] E_REJ    = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic expect_at(input int dt, input logic [4:0] vec);
        sb.push_back('{cyc + dt, vec});
    endtask

    // Advance one clock and compare the outputs with the scoreboard head.
    task automatic tick();
        logic [4:0] obs;
        exp_t       e;
        @(posedge clk);
        #1;
        cyc++;
        obs = {start, start_N, stop, avto, rejected};
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk($sformatf("out@%0d", cyc), int'(obs), int'(e.vec));
        end else if (obs != 5'b0) begin
            chk($sformatf("unexpected@%0d", cyc), int'(obs), 0);
        end
    endtask

    task automatic settle(input int n, input string tag);
        repeat (n) tick();
        chk(tag, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        btn_start = 1'b0; btn_start_n = 1'b0; btn_stop = 1'b1; btn_avto = 1'b0;

        // Reset with stop already pressed
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outputs", int'({start, start_N, stop, avto, rejected, busy}), 0);
        end
        rst = 1'b0;
        expect_at(7, E_STOP);
        repeat (7) tick();
        chk("busy_after_stop", int'(busy), 0);
        btn_stop = 1'b0;
        settle(15, "drain_reset");

        // Bouncing start, then held
        for (int i = 0; i < 2; i++) begin
            btn_start = 1'b1; tick(); tick();
            btn_start = 1'b0; tick(); tick();
        end
        btn_start = 1'b1;
        expect_at(7, E_START);
        repeat (7) tick();
        chk("busy_after_start", int'(busy), 1);
        repeat (20) tick();
        btn_start = 1'b0;
        settle(25, "drain_debounce");

        // Same-cycle stop and start
        btn_stop = 1'b1; btn_start = 1'b1;
        expect_at(7, E_STOP | E_REJ);
        repeat (10) tick();
        chk("busy_after_prio", int'(busy), 0);
        btn_stop = 1'b0; btn_start = 1'b0;
        settle(20, "drain_prio");

        // Holdoff: avto rejected at +8, second avto lands exactly at +16
        btn_start = 1'b1;
        expect_at(7, E_START);
        expect_at(15, E_REJ);
        expect_at(23, E_AVTO);
        for (int r = 1; r <= 30; r++) begin
            tick();
            if (r == 8)  btn_avto = 1'b1;
            if (r == 10) btn_start = 1'b0;
            if (r == 12) btn_avto = 1'b0;
            if (r == 15) chk("busy_holdoff", int'(busy), 1);
            if (r == 16) btn_avto = 1'b1;
        end
        btn_avto = 1'b0;
        settle(30, "drain_holdoff");

        // Stop during holdoff
        btn_start = 1'b1;
        expect_at(7, E_START);
        expect_at(12, E_STOP);
        for (int r = 1; r <= 30; r++) begin
            tick();
            if (r == 5)  btn_stop = 1'b1;
            if (r == 10) begin btn_start = 1'b0; btn_stop = 1'b0; end
            if (r == 13) chk("busy_after_stop_in_hold", int'(busy), 1);
            if (r == 22) chk("busy_last_hold_cycle", int'(busy), 1);
            if (r == 23) chk("busy_hold_expired", int'(busy), 0);
        end
        settle(20, "drain_stop_hold");

        // Reset in the middle of a start_N debounce
        btn_start_n = 1'b1;
        expect_at(13, E_STARTN);
        for (int r = 1; r <= 20; r++) begin
            tick();
            if (r == 4) rst = 1'b1;
            if (r == 6) begin
                chk("busy_in_rst", int'(busy), 0);
                rst = 1'b0;
            end
        end
        btn_start_n = 1'b0;
        settle(20, "drain_mid_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
